dmem_port_arbiter: RTL and testbench

Shares the single data-memory port between the processor's memory stage and a write-only peripheral requester, such as the sonar sample logger. Peripheral writes are queued in a small FIFO and drained into idle memory slots. The processor has priority, with two exceptions: an anti-starvation counter can force a drain cycle, and a processor load that hits a queued address stalls until that write has drained. The block sits between the processor's dmem outputs and the dmem instance in the wrapper.

---
 rtl/dmem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the processor memory stage and a write-only
// peripheral. Peripheral writes are queued and drained into idle memory slots.
module dmem_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic                   cpu_wren,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_data,
  output logic [31:0]            cpu_q,
  output logic                   cpu_stall,
  input  logic                   per_valid,
  input  logic [31:0]            per_addr,
  input  logic [31:0]            per_data,
  output logic                   per_ready,
  output logic [31:0]            address_dmem,
  output logic [31:0]            data,
  output logic                   wren,
  input  logic [31:0]            q_dmem,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_CPU,
    SLOT_DRAIN
  } slot_t;

  logic [31:0]   fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic          has_data;
  logic          force_drain;
  logic          hit;
  logic          hazard;
  logic          push;
  logic          pop;
  logic [AW-1:0] offset;
  slot_t         slot;

  assign has_data    = (count != '0);
  assign per_ready   = (count != CW'(DEPTH));
  assign force_drain = (starve_cnt == SW'(STARVE_LIMIT)) && has_data;
  assign hazard      = cpu_req && !cpu_wren && hit;
  assign push        = per_valid && per_ready;
  assign pop         = (slot == SLOT_DRAIN);
  assign cpu_q       = q_dmem;
  assign fifo_count  = count;

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    hit    = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = AW'(i) - head;
      if (({1'b0, offset} < count) && (fifo_addr[i] == cpu_addr)) begin
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    slot      = SLOT_IDLE;
    cpu_stall = 1'b0;
    if (force_drain) begin
      slot      = SLOT_DRAIN;
      cpu_stall = cpu_req;
    end else if (hazard) begin
      slot      = SLOT_DRAIN;
      cpu_stall = 1'b1;
    end else if (cpu_req) begin
      slot = SLOT_CPU;
    end else if (has_data) begin
      slot = SLOT_DRAIN;
    end
  end

  always_comb begin
    address_dmem = cpu_addr;
    data         = cpu_data;
    wren         = 1'b0;
    case (slot)
      SLOT_CPU: wren = cpu_wren;
      SLOT_DRAIN: begin
        address_dmem = fifo_addr[head];
        data         = fifo_data[head];
        wren         = 1'b1;
      end
      default: wren = 1'b0;
    endcase
  end

  // Storage is not reset; the count alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[tail] <= per_addr;
      fifo_data[tail] <= per_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (pop || !has_data) begin
        starve_cnt <= '0;
      end else if ((slot == SLOT_CPU) && (starve_cnt != SW'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a vector table covering drain order, full
// FIFO, starvation, RAW hazards and pointer wrap, plus a hand-written async reset sequence.
module tb_dmem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_wren;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data;
  logic [31:0] cpu_q;
  logic        cpu_stall;
  logic        per_valid;
  logic [31:0] per_addr;
  logic [31:0] per_data;
  logic        per_ready;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        req;
    logic        wr;
    logic [31:0] ca;
    logic [31:0] cd;
    logic        pv;
    logic [31:0] pa;
    logic [31:0] pd;
    logic        ew;
    logic [31:0] ea;
    logic [31:0] ed;
    logic        es;
    logic        er;
    logic [2:0]  ec;
  } vec_t;

  vec_t vecs[$];

  dmem_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_q(cpu_q), .cpu_stall(cpu_stall),
    .per_valid(per_valid), .per_addr(per_addr), .per_data(per_data), .per_ready(per_ready),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic req, input logic wr, input logic [31:0] ca,
                              input logic [31:0] cd, input logic pv, input logic [31:0] pa,
                              input logic [31:0] pd, input logic ew, input logic [31:0] ea,
                              input logic [31:0] ed, input logic es, input logic er,
                              input logic [2:0] ec);
    vec_t v;
    v.req = req; v.wr = wr; v.ca = ca; v.cd = cd;
    v.pv = pv; v.pa = pa; v.pd = pd;
    v.ew = ew; v.ea = ea; v.ed = ed; v.es = es; v.er = er; v.ec = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    cpu_req   = v.req;
    cpu_wren  = v.wr;
    cpu_addr  = v.ca;
    cpu_data  = v.cd;
    per_valid = v.pv;
    per_addr  = v.pa;
    per_data  = v.pd;
    q_dmem    = v.ca ^ 32'h5A5A_0000;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check($sformatf("vec%0d wren", idx),         32'(wren),         32'(v.ew));
    check($sformatf("vec%0d address_dmem", idx), address_dmem,      v.ea);
    check($sformatf("vec%0d data", idx),         data,              v.ed);
    check($sformatf("vec%0d cpu_stall", idx),    32'(cpu_stall),    32'(v.es));
    check($sformatf("vec%0d per_ready", idx),    32'(per_ready),    32'(v.er));
    check($sformatf("vec%0d fifo_count", idx),   32'(fifo_count),   32'(v.ec));
    check($sformatf("vec%0d cpu_q", idx),        cpu_q,             v.ca ^ 32'h5A5A_0000);
  endtask

  task automatic runRow(input vec_t v, input int idx);
    applyStimulus(v);
    @(negedge clock);
    checkOutput(v, idx);
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Idle CPU: each peripheral write drains the cycle after its push.
    vecs.push_back(mk(0,0,32'h1234,32'hCAFE, 1,32'h100,32'hD0, 0,32'h1234,32'hCAFE, 0,1,0));
    vecs.push_back(mk(0,0,32'h1234,32'hCAFE, 1,32'h104,32'hD1, 1,32'h100,32'hD0,   0,1,1));
    vecs.push_back(mk(0,0,32'h1234,32'hCAFE, 1,32'h108,32'hD2, 1,32'h104,32'hD1,   0,1,1));
    vecs.push_back(mk(0,0,32'h1234,32'hCAFE, 1,32'h10C,32'hD3, 1,32'h108,32'hD2,   0,1,1));
    vecs.push_back(mk(0,0,32'h1234,32'hCAFE, 0,32'h0,32'h0,    1,32'h10C,32'hD3,   0,1,1));
    vecs.push_back(mk(0,0,32'h1234,32'hCAFE, 0,32'h0,32'h0,    0,32'h1234,32'hCAFE, 0,1,0));

    // Busy CPU stores fill the FIFO; fifth write waits; forced drain after 8 lost slots.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,1,32'h1000,32'h1111, 1,32'h200+4*i,32'hB0+i,
                        1,32'h1000,32'h1111, 0,1,3'(i)));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1,1,32'h1000,32'h1111, 1,32'h210,32'hB4, 1,32'h1000,32'h1111, 0,0,4));
    vecs.push_back(mk(1,1,32'h1000,32'h1111, 1,32'h210,32'hB4, 1,32'h200,32'hB0,   1,0,4));
    vecs.push_back(mk(1,1,32'h1000,32'h1111, 1,32'h210,32'hB4, 1,32'h1000,32'h1111, 0,1,3));
    vecs.push_back(mk(1,1,32'h1000,32'h1111, 0,32'h0,32'h0,    1,32'h1000,32'h1111, 0,0,4));
    for (int i = 1; i < 5; i++)
      vecs.push_back(mk(0,0,32'h1000,32'h1111, 0,32'h0,32'h0, 1,32'h200+4*i,32'hB0+i,
                        0,(i != 1),3'(5-i)));
    vecs.push_back(mk(0,0,32'h1000,32'h1111, 0,32'h0,32'h0, 0,32'h1000,32'h1111, 0,1,0));

    // Simultaneous push and pop at count 2 across the pointer wrap.
    vecs.push_back(mk(1,1,32'h3000,32'h3333, 1,32'h300,32'hE0, 1,32'h3000,32'h3333, 0,1,0));
    vecs.push_back(mk(1,1,32'h3000,32'h3333, 1,32'h304,32'hE1, 1,32'h3000,32'h3333, 0,1,1));
    for (int i = 2; i < 6; i++)
      vecs.push_back(mk(0,0,32'h3000,32'h3333, 1,32'h300+4*i,32'hE0+i,
                        1,32'h300+4*(i-2),32'hE0+i-2, 0,1,2));
    vecs.push_back(mk(0,0,32'h3000,32'h3333, 0,32'h0,32'h0, 1,32'h310,32'hE4, 0,1,2));
    vecs.push_back(mk(0,0,32'h3000,32'h3333, 0,32'h0,32'h0, 1,32'h314,32'hE5, 0,1,1));
    vecs.push_back(mk(0,0,32'h3000,32'h3333, 0,32'h0,32'h0, 0,32'h3000,32'h3333, 0,1,0));

    // RAW hazards: head match, store to a queued address, and a non-head match.
    vecs.push_back(mk(1,1,32'h3000,32'h3333, 1,32'h40,32'hBEEF, 1,32'h3000,32'h3333, 0,1,0));
    vecs.push_back(mk(1,0,32'h40,32'h0,      0,32'h0,32'h0,     1,32'h40,32'hBEEF,   1,1,1));
    vecs.push_back(mk(1,0,32'h40,32'h0,      0,32'h0,32'h0,     0,32'h40,32'h0,      0,1,0));
    vecs.push_back(mk(1,1,32'h3000,32'h3333, 1,32'h50,32'h5555, 1,32'h3000,32'h3333, 0,1,0));
    vecs.push_back(mk(1,1,32'h50,32'h7777,   0,32'h0,32'h0,     1,32'h50,32'h7777,   0,1,1));
    vecs.push_back(mk(1,0,32'h50,32'h0,      0,32'h0,32'h0,     1,32'h50,32'h5555,   1,1,1));
    vecs.push_back(mk(1,0,32'h50,32'h0,      0,32'h0,32'h0,     0,32'h50,32'h0,      0,1,0));
    vecs.push_back(mk(1,1,32'h3000,32'h3333, 1,32'h60,32'h6666, 1,32'h3000,32'h3333, 0,1,0));
    vecs.push_back(mk(1,1,32'h3000,32'h3333, 1,32'h64,32'h6464, 1,32'h3000,32'h3333, 0,1,1));
    vecs.push_back(mk(1,0,32'h64,32'h0,      0,32'h0,32'h0,     1,32'h60,32'h6666,   1,1,2));
    vecs.push_back(mk(1,0,32'h64,32'h0,      0,32'h0,32'h0,     1,32'h64,32'h6464,   1,1,1));
    vecs.push_back(mk(1,0,32'h64,32'h0,      0,32'h0,32'h0,     0,32'h64,32'h0,      0,1,0));

    // Starvation with one queued entry: eight CPU slots, then a forced drain.
    vecs.push_back(mk(1,1,32'h2000,32'h2222, 1,32'h400,32'hC0C0, 1,32'h2000,32'h2222, 0,1,0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1,1,32'h2000,32'h2222, 0,32'h0,32'h0, 1,32'h2000,32'h2222, 0,1,1));
    vecs.push_back(mk(1,1,32'h2000,32'h2222, 0,32'h0,32'h0, 1,32'h400,32'hC0C0,   1,1,1));
    vecs.push_back(mk(1,1,32'h2000,32'h2222, 0,32'h0,32'h0, 1,32'h2000,32'h2222, 0,1,0));

    reset     = 1'b0;
    cpu_req   = 1'b0;
    cpu_wren  = 1'b0;
    cpu_addr  = '0;
    cpu_data  = '0;
    per_valid = 1'b0;
    per_addr  = '0;
    per_data  = '0;
    q_dmem    = '0;
    #3;
    check("reset fifo_count", 32'(fifo_count), 32'd0);
    check("reset per_ready",  32'(per_ready),  32'd1);
    check("reset wren",       32'(wren),       32'd0);
    check("reset cpu_stall",  32'(cpu_stall),  32'd0);
    #20;
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < vecs.size(); i++) runRow(vecs[i], i);

    // Async reset with three entries queued: flushes immediately, nothing stale drains.
    for (int i = 0; i < 3; i++)
      runRow(mk(1,1,32'h3000,32'h3333, 1,32'h500+4*i,32'hF0+i,
                1,32'h3000,32'h3333, 0,1,3'(i)), 1000 + i);
    cpu_req   = 1'b0;
    per_valid = 1'b0;
    #1;
    check("pre-reset wren",         32'(wren),       32'd1);
    check("pre-reset address_dmem", address_dmem,    32'h500);
    #1;
    reset = 1'b0;
    #1;
    check("async reset fifo_count", 32'(fifo_count), 32'd0);
    check("async reset wren",       32'(wren),       32'd0);
    check("async reset per_ready",  32'(per_ready),  32'd1);
    cpu_req  = 1'b1;
    cpu_wren = 1'b0;
    cpu_addr = 32'h500;
    #1;
    check("async reset load stall", 32'(cpu_stall),  32'd0);
    check("async reset load wren",  32'(wren),       32'd0);
    #3;
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++)
      runRow(mk(0,0,32'h500,32'h0, 0,32'h0,32'h0, 0,32'h500,32'h0, 0,1,0), 2000 + i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
